// File: rtl/midi_pkg.sv
// Shared MIDI constants, FSM encoding and byte-class record used by the
// CC receiver and the volume sender.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF    = 4'h8;
  localparam logic [3:0] MIDI_CC          = 4'hB;
  localparam logic [3:0] MIDI_PC          = 4'hC;
  localparam logic [3:0] MIDI_CHAN_PRESS  = 4'hD;

  localparam logic [6:0] MIDI_CC_VOLUME   = 7'd7;

  localparam logic [7:0] MIDI_RT_MIN      = 8'hF8;
  localparam logic [7:0] MIDI_SYSEX_START = 8'hF0;
  localparam logic [7:0] MIDI_SYSEX_END   = 8'hF7;

  typedef enum logic [1:0] {
    ST_NOSTAT = 2'd0,
    ST_D1     = 2'd1,
    ST_D2     = 2'd2
  } midi_state_t;

  typedef struct packed {
    logic       is_data;
    logic       is_chan_status;
    logic       is_syscom;
    logic       is_realtime;
    logic [1:0] data_count;
  } byte_class_t;

  // Program change and channel pressure carry one data byte; the rest carry two.
  function automatic logic [1:0] data_bytes_for(input logic [7:0] status);
    if (status[7:4] == MIDI_PC || status[7:4] == MIDI_CHAN_PRESS)
      return 2'd1;
    return 2'd2;
  endfunction

endpackage

// File: rtl/midi_byte_classifier.sv
// Combinational decode of a received MIDI byte into its class and, for
// channel status bytes, the number of data bytes the message carries.
module midi_byte_classifier
  import midi_pkg::*;
(
  input  logic [7:0]  rx_byte,
  output byte_class_t cls
);

  // NOTE: every field gets a value on every path, so no latch is inferred.
  always_comb begin
    cls                = '0;
    cls.is_data        = ~rx_byte[7];
    cls.is_chan_status = rx_byte[7] && (rx_byte < MIDI_SYSEX_START);
    cls.is_syscom      = (rx_byte >= MIDI_SYSEX_START) && (rx_byte < MIDI_RT_MIN);
    cls.is_realtime    = (rx_byte >= MIDI_RT_MIN);
    if (cls.is_chan_status)
      cls.data_count = data_bytes_for(rx_byte);
  end

endmodule

// File: rtl/midi_cc_receiver.sv
// MIDI receive parser: decodes Control Change messages with running status,
// transparent real-time bytes, a held volume register and an orphan counter.
module midi_cc_receiver
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL      = 4'd0,
  parameter logic [6:0] VOLUME_CC    = MIDI_CC_VOLUME,
  parameter logic [6:0] VOLUME_RESET = 7'd127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       cc_valid,
  output logic [3:0] cc_channel,
  output logic [6:0] cc_number,
  output logic [6:0] cc_value,
  output logic [6:0] volume,
  output logic       volume_update,
  output logic [7:0] err_count
);

  byte_class_t cls;
  midi_state_t state;
  logic [7:0]  run_status;
  logic [1:0]  need;
  logic [6:0]  d1;
  logic        in_sysex;

  midi_byte_classifier u_classifier (
    .rx_byte (rx_byte),
    .cls     (cls)
  );

  // NOTE: all state uses non-blocking assignments so every branch sees the
  // pre-edge values, matching the register behaviour.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_NOSTAT;
      run_status    <= '0;
      need          <= '0;
      d1            <= '0;
      in_sysex      <= 1'b0;
      cc_valid      <= 1'b0;
      cc_channel    <= '0;
      cc_number     <= '0;
      cc_value      <= '0;
      volume        <= VOLUME_RESET;
      volume_update <= 1'b0;
      err_count     <= '0;
    end else begin
      cc_valid      <= 1'b0;
      volume_update <= 1'b0;
      // Real-time bytes fall through untouched, even mid-message.
      if (rx_valid && !cls.is_realtime) begin
        if (cls.is_chan_status) begin
          run_status <= rx_byte;
          need       <= cls.data_count;
          in_sysex   <= 1'b0;
          state      <= ST_D1;
        end else if (cls.is_syscom) begin
          run_status <= '0;
          in_sysex   <= (rx_byte == MIDI_SYSEX_START);
          state      <= ST_NOSTAT;
        end else if (cls.is_data) begin
          case (state)
            ST_NOSTAT: begin
              if (!in_sysex && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            end
            ST_D1: begin
              // One-byte messages complete here and are not CCs.
              if (need != 2'd1) begin
                d1    <= rx_byte[6:0];
                state <= ST_D2;
              end
            end
            ST_D2: begin
              state <= ST_D1;
              if (run_status[7:4] == MIDI_CC) begin
                cc_valid   <= 1'b1;
                cc_channel <= run_status[3:0];
                cc_number  <= d1;
                cc_value   <= rx_byte[6:0];
                if (run_status[3:0] == CHANNEL && d1 == VOLUME_CC) begin
                  volume        <= rx_byte[6:0];
                  volume_update <= 1'b1;
                end
              end
            end
            default: state <= ST_NOSTAT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_cc_receiver.sv
// Self-checking bench for midi_cc_receiver: directed vector table, reset
// corner sequences, and randomized bytes against a message-level model.
module tb_midi_cc_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic       cc_valid;
  logic [3:0] cc_channel;
  logic [6:0] cc_number;
  logic [6:0] cc_value;
  logic [6:0] volume;
  logic       volume_update;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  midi_cc_receiver dut (
    .clk           (clk),
    .rst           (rst),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .cc_valid      (cc_valid),
    .cc_channel    (cc_channel),
    .cc_number     (cc_number),
    .cc_value      (cc_value),
    .volume        (volume),
    .volume_update (volume_update),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_before;
    logic [7:0] b;
    logic       cc;
    logic [3:0] ch;
    logic [6:0] num;
    logic [6:0] val;
    logic [6:0] vol;
    logic       vu;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit r, logic [7:0] b, logic cc, logic [3:0] ch,
                             logic [6:0] num, logic [6:0] val, logic [6:0] vol,
                             logic vu, logic [7:0] err);
    vec_t x;
    x.rst_before = r; x.b = b; x.cc = cc; x.ch = ch; x.num = num;
    x.val = val; x.vol = vol; x.vu = vu; x.err = err;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, outputs are sampled 1 time unit after posedge.
  task automatic step(input logic valid, input logic [7:0] b);
    @(negedge clk);
    rx_valid = valid;
    rx_byte  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input logic valid, input logic [7:0] b);
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = valid;
    rx_byte  = b;
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
  endtask

  // Reference model: message-level view with a pending data-byte queue.
  int         m_rs;
  bit         m_sysex;
  logic [6:0] m_pend[$];
  logic       m_cc, m_vu;
  logic [3:0] m_ch;
  logic [6:0] m_num, m_val, m_vol;
  int         m_err;

  function automatic void model_reset();
    m_rs = -1; m_sysex = 0; m_pend.delete();
    m_cc = 0; m_vu = 0; m_ch = 0; m_num = 0; m_val = 0; m_vol = 7'd127; m_err = 0;
  endfunction

  function automatic void model_byte(input logic valid, input logic [7:0] b);
    int needed;
    m_cc = 0;
    m_vu = 0;
    if (!valid || b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_rs = -1; m_pend.delete(); m_sysex = (b == 8'hF0);
    end else if (b >= 8'h80) begin
      m_rs = b; m_pend.delete(); m_sysex = 0;
    end else if (m_rs < 0) begin
      if (!m_sysex && m_err < 255) m_err++;
    end else begin
      m_pend.push_back(b[6:0]);
      needed = ((m_rs >> 4) == 'hC || (m_rs >> 4) == 'hD) ? 1 : 2;
      if (m_pend.size() == needed) begin
        if (needed == 2 && (m_rs >> 4) == 'hB) begin
          m_cc = 1; m_ch = 4'(m_rs & 'hF); m_num = m_pend[0]; m_val = m_pend[1];
          if (m_ch == 4'd0 && m_num == 7'd7) begin
            m_vol = m_val; m_vu = 1;
          end
        end
        m_pend.delete();
      end
    end
  endfunction

  task automatic compare_model(input string tag);
    check({tag, " cc_valid"},      cc_valid,      m_cc);
    check({tag, " cc_channel"},    cc_channel,    m_ch);
    check({tag, " cc_number"},     cc_number,     m_num);
    check({tag, " cc_value"},      cc_value,      m_val);
    check({tag, " volume"},        volume,        m_vol);
    check({tag, " volume_update"}, volume_update, m_vu);
    check({tag, " err_count"},     err_count,     32'(m_err));
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    logic [3:0] ch = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
    if (r < 45) return ($urandom_range(0, 2) == 0) ? 8'h07 : 8'($urandom_range(0, 127));
    if (r < 65) return {4'hB, ch};
    if (r < 72) return {($urandom_range(0, 1) == 0) ? 4'hC : 4'hD, ch};
    if (r < 78) return {4'($urandom_range(8, 10)), ch};
    if (r < 82) return 8'hF0;
    if (r < 85) return 8'hF7;
    if (r < 87) return 8'($urandom_range('hF1, 'hF6));
    if (r < 95) return 8'($urandom_range('hF8, 'hFF));
    return 8'h07;
  endfunction

  initial begin
    // rst  byte  cc ch  num    val    vol    vu  err
    vecs.push_back(v(0, 8'hB0, 0, 0, 7'h00, 7'h00, 7'h7F, 0, 0));
    vecs.push_back(v(0, 8'h07, 0, 0, 7'h00, 7'h00, 7'h7F, 0, 0));
    vecs.push_back(v(0, 8'h40, 1, 0, 7'h07, 7'h40, 7'h40, 1, 0));
    vecs.push_back(v(0, 8'hB0, 0, 0, 7'h07, 7'h40, 7'h40, 0, 0));
    vecs.push_back(v(0, 8'h07, 0, 0, 7'h07, 7'h40, 7'h40, 0, 0));
    vecs.push_back(v(0, 8'h10, 1, 0, 7'h07, 7'h10, 7'h10, 1, 0));
    vecs.push_back(v(0, 8'h07, 0, 0, 7'h07, 7'h10, 7'h10, 0, 0));
    vecs.push_back(v(0, 8'h20, 1, 0, 7'h07, 7'h20, 7'h20, 1, 0));
    vecs.push_back(v(0, 8'hB0, 0, 0, 7'h07, 7'h20, 7'h20, 0, 0));
    vecs.push_back(v(0, 8'hF8, 0, 0, 7'h07, 7'h20, 7'h20, 0, 0));
    vecs.push_back(v(0, 8'h07, 0, 0, 7'h07, 7'h20, 7'h20, 0, 0));
    vecs.push_back(v(0, 8'hFE, 0, 0, 7'h07, 7'h20, 7'h20, 0, 0));
    vecs.push_back(v(0, 8'h7F, 1, 0, 7'h07, 7'h7F, 7'h7F, 1, 0));
    vecs.push_back(v(0, 8'hB1, 0, 0, 7'h07, 7'h7F, 7'h7F, 0, 0));
    vecs.push_back(v(0, 8'h07, 0, 0, 7'h07, 7'h7F, 7'h7F, 0, 0));
    vecs.push_back(v(0, 8'h30, 1, 1, 7'h07, 7'h30, 7'h7F, 0, 0));
    vecs.push_back(v(0, 8'hC0, 0, 1, 7'h07, 7'h30, 7'h7F, 0, 0));
    vecs.push_back(v(0, 8'h05, 0, 1, 7'h07, 7'h30, 7'h7F, 0, 0));
    vecs.push_back(v(0, 8'h07, 0, 1, 7'h07, 7'h30, 7'h7F, 0, 0));
    vecs.push_back(v(0, 8'h40, 0, 1, 7'h07, 7'h30, 7'h7F, 0, 0));
    vecs.push_back(v(1, 8'h07, 0, 0, 7'h00, 7'h00, 7'h7F, 0, 1));
    vecs.push_back(v(0, 8'h40, 0, 0, 7'h00, 7'h00, 7'h7F, 0, 2));
    vecs.push_back(v(0, 8'hF0, 0, 0, 7'h00, 7'h00, 7'h7F, 0, 2));
    vecs.push_back(v(0, 8'h01, 0, 0, 7'h00, 7'h00, 7'h7F, 0, 2));
    vecs.push_back(v(0, 8'h02, 0, 0, 7'h00, 7'h00, 7'h7F, 0, 2));
    vecs.push_back(v(0, 8'hF7, 0, 0, 7'h00, 7'h00, 7'h7F, 0, 2));
    vecs.push_back(v(0, 8'h05, 0, 0, 7'h00, 7'h00, 7'h7F, 0, 3));

    pulse_reset(1'b0, 8'h00);
    check("reset cc_valid",      cc_valid,      0);
    check("reset cc_channel",    cc_channel,    0);
    check("reset cc_number",     cc_number,     0);
    check("reset cc_value",      cc_value,      0);
    check("reset volume",        volume,        7'd127);
    check("reset volume_update", volume_update, 0);
    check("reset err_count",     err_count,     0);

    // Table steps are back-to-back: rx_valid stays high between entries.
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].rst_before) pulse_reset(1'b0, 8'h00);
      step(1'b1, vecs[i].b);
      check({tag, " cc_valid"},      cc_valid,      vecs[i].cc);
      check({tag, " cc_channel"},    cc_channel,    vecs[i].ch);
      check({tag, " cc_number"},     cc_number,     vecs[i].num);
      check({tag, " cc_value"},      cc_value,      vecs[i].val);
      check({tag, " volume"},        volume,        vecs[i].vol);
      check({tag, " volume_update"}, volume_update, vecs[i].vu);
      check({tag, " err_count"},     err_count,     vecs[i].err);
    end

    // Orphan counter saturates at 255 and does not wrap.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'(i % 128));
      if (i == 251) check("sat err_count 255 reached", err_count, 8'd255);
    end
    check("sat err_count held", err_count, 8'd255);

    // Reset mid-message aborts it; the next data byte is an orphan.
    pulse_reset(1'b0, 8'h00);
    step(1'b1, 8'hB0);
    step(1'b1, 8'h07);
    pulse_reset(1'b0, 8'h00);
    step(1'b1, 8'h40);
    check("midrst cc_valid",  cc_valid,  0);
    check("midrst err_count", err_count, 8'd1);
    check("midrst volume",    volume,    7'd127);

    // Reset wins over a simultaneous byte: the status byte is lost.
    pulse_reset(1'b1, 8'hB0);
    step(1'b1, 8'h07);
    step(1'b1, 8'h40);
    check("rstprio cc_valid",  cc_valid,  0);
    check("rstprio err_count", err_count, 8'd2);

    // Randomized traffic with idle gaps against the model.
    pulse_reset(1'b0, 8'h00);
    model_reset();
    compare_model("rnd_reset");
    for (int i = 0; i < 3000; i++) begin
      logic       vld;
      logic [7:0] b;
      vld = ($urandom_range(0, 4) != 0);
      b   = rand_byte();
      step(vld, b);
      model_byte(vld, b);
      compare_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
